// File: rtl/wavefront_drain_if.sv
// Stream bundle for wavefront_drain: skewed wavefront in, serialised beats out.
interface wavefront_drain_if #(
  parameter int C_WIDTH = 16,
  parameter int WPB     = 2,
  parameter int N       = 4
);
  logic                   valid_in;
  logic [N*C_WIDTH-1:0]   data_in;
  logic                   valid_out;
  logic [C_WIDTH*WPB-1:0] data_out;
  logic                   overflow;

  modport master (output valid_in, data_in, input valid_out, data_out, overflow);
  modport slave  (input valid_in, data_in, output valid_out, data_out, overflow);
endinterface

// File: rtl/wavefront_drain.sv
// Systolic drain: deskews a wavefront into WPB-word beats, queues them per stage and
// serialises one beat per cycle. Define DRAIN_OVERFLOW_CHK_EN to compile in queue-full drop/overflow.
module wavefront_drain #(
  parameter int C_WIDTH = 16,
  parameter int WPB     = 2,
  parameter int N       = 4,
  parameter int QDEPTH  = 64
) (
  input  logic             clk,
  input  logic             rst,
  wavefront_drain_if.slave bus
);
  localparam int S   = N / WPB;
  localparam int SW  = C_WIDTH * WPB;
  localparam int VD  = (N > 1) ? N - 1 : 1;
  localparam int AW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int SCW = $clog2(S + 1);
`ifdef DRAIN_OVERFLOW_CHK_EN
  localparam int CW  = $clog2(QDEPTH + 1);
`endif

  typedef logic signed [C_WIDTH-1:0] word_t;

  if ((N % WPB) != 0) begin : g_bad_cfg
    $error("wavefront_drain: N (%0d) must be a multiple of WPB (%0d)", N, WPB);
  end

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---- p0: per-word deskew and per-stage valid delay ----
  word_t            aligned [N];
  logic [SW-1:0]    beat_p0 [S];
  logic             vld_p0  [S];
  logic [VD-1:0]    vld_dly;

  for (genvar k = 0; k < N; k++) begin : g_word
    localparam int J = k % WPB;
    localparam int D = WPB - 1 - J;
    word_t word_in;
    assign word_in = $signed(bus.data_in[C_WIDTH*k +: C_WIDTH]);

    if (D == 0) begin : g_thru
      assign aligned[k] = word_in;
    end else begin : g_dly
      word_t dly [D];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int d = 0; d < D; d++) dly[d] <= '0;
        end else begin
          dly[0] <= word_in;
          for (int d = 1; d < D; d++) dly[d] <= dly[d-1];
        end
      end
      assign aligned[k] = dly[D-1];
    end
  end

  always_comb begin
    for (int i = 0; i < S; i++) begin
      beat_p0[i] = '0;
      for (int j = 0; j < WPB; j++) beat_p0[i][C_WIDTH*j +: C_WIDTH] = aligned[i*WPB + j];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_dly <= '0;
    else      vld_dly <= VD'({vld_dly, bus.valid_in});
  end

  for (genvar i = 0; i < S; i++) begin : g_vld
    localparam int A = i*WPB + WPB - 1;
    if (A == 0) begin : g_now
      assign vld_p0[i] = bus.valid_in;
    end else begin : g_tap
      assign vld_p0[i] = vld_dly[A-1];
    end
  end

  // ---- p1: per-stage queues with latency-matched presentation ----
  logic [SW-1:0] head_p1     [S];
  logic          head_vld_p1 [S];
  logic          ready;
  logic          deq;
`ifdef DRAIN_OVERFLOW_CHK_EN
  logic          drop [S];
`endif

  assign deq = ready && head_vld_p1[0];

  for (genvar i = 0; i < S; i++) begin : g_stage
    // Residence time that makes every beat of a wavefront presentable in the same cycle.
    localparam int L = WPB*S - i*WPB - (WPB - 1);
    logic [SW-1:0] mem [QDEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   pres;
    logic [L-1:0]  age;
    logic          enq, matured, deq_i;
`ifdef DRAIN_OVERFLOW_CHK_EN
    logic [CW-1:0] occ;
    assign drop[i] = vld_p0[i] && (occ == CW'(QDEPTH));
    assign enq     = vld_p0[i] && !drop[i];
`else
    assign enq     = vld_p0[i];
`endif
    assign matured        = age[L-1];
    assign head_vld_p1[i] = (pres != '0) || matured;
    assign head_p1[i]     = mem[rd_ptr];
    assign deq_i          = deq && head_vld_p1[i];

    always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= beat_p0[i];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        pres   <= '0;
        age    <= '0;
      end else begin
        age <= L'({age, enq});
        if (enq)   wr_ptr <= ptr_inc(wr_ptr);
        if (deq_i) rd_ptr <= ptr_inc(rd_ptr);
        case ({matured, deq_i})
          2'b10:   pres <= pres + 1'b1;
          2'b01:   pres <= pres - 1'b1;
          default: pres <= pres;
        endcase
      end
    end

`ifdef DRAIN_OVERFLOW_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        occ <= '0;
      end else begin
        case ({enq, deq_i})
          2'b10:   occ <= occ + 1'b1;
          2'b01:   occ <= occ - 1'b1;
          default: occ <= occ;
        endcase
        if (drop[i]) $error("wavefront_drain: stage %0d queue full, beat dropped", i);
      end
    end
`endif
  end

  // ---- p2: parallel-to-serial shifter ----
  logic [SW-1:0]  shift_p2 [S];
  logic [SCW-1:0] cnt_p2;

  assign ready = (cnt_p2 <= SCW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_p2 <= '0;
      for (int s = 0; s < S; s++) shift_p2[s] <= '0;
    end else if (deq) begin
      cnt_p2 <= SCW'(S);
      for (int s = 0; s < S; s++) shift_p2[s] <= head_p1[s];
    end else if (cnt_p2 != '0) begin
      cnt_p2 <= cnt_p2 - 1'b1;
      for (int s = 0; s < S - 1; s++) shift_p2[s] <= shift_p2[s+1];
      shift_p2[S-1] <= '0;
    end
  end

  assign bus.data_out  = shift_p2[0];
  assign bus.valid_out = (cnt_p2 != '0);

`ifdef DRAIN_OVERFLOW_CHK_EN
  logic ovf;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else begin
      for (int s = 0; s < S; s++) if (drop[s]) ovf <= 1'b1;
    end
  end
  assign bus.overflow = ovf;
`else
  assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_wavefront_drain.sv
// Directed/random bench for wavefront_drain against a cycle-schedule reference model.
module tb_wavefront_drain;
  localparam int CW   = 16;
  localparam int WPB  = 2;
  localparam int N    = 4;
  localparam int S    = N / WPB;
  localparam int SW   = CW * WPB;
  localparam int QD   = 64;
  localparam int MAXC = 400;
  localparam int LAT  = WPB * S + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wavefront_drain_if #(.C_WIDTH(CW), .WPB(WPB), .N(N)) bus ();
  wavefront_drain #(.C_WIDTH(CW), .WPB(WPB), .N(N), .QDEPTH(QD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit stress = 1'b0;
  int last_e;

  logic          in_vld   [MAXC];
  logic [CW-1:0] in_word  [MAXC][N];
  logic          exp_vld  [MAXC];
  logic [SW-1:0] exp_data [MAXC];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_sched();
    for (int c = 0; c < MAXC; c++) begin
      in_vld[c]   = 1'b0;
      exp_vld[c]  = 1'b0;
      exp_data[c] = '0;
      for (int k = 0; k < N; k++) in_word[c][k] = CW'($urandom);
    end
    last_e = -100;
  endtask

  // Wavefront presentable LAT-1 cycles after valid_in; shifter then emits S beats back-to-back.
  task automatic add_wave(input int t, input logic [CW-1:0] w [N], output int e);
    in_vld[t] = 1'b1;
    for (int k = 0; k < N; k++) if (t + k < MAXC) in_word[t+k][k] = w[k];
    e = (t + LAT > last_e + S) ? t + LAT : last_e + S;
    last_e = e;
    for (int i = 0; i < S; i++) begin
      if (e + i < MAXC) begin
        exp_vld[e+i] = 1'b1;
        for (int j = 0; j < WPB; j++) exp_data[e+i][CW*j +: CW] = w[i*WPB + j];
      end
    end
  endtask

  task automatic run(input int len, input int rst_cyc, input int lim);
    logic          pv;
    logic [SW-1:0] pd;
    pv = 1'b0;
    pd = '0;
    if (rst_cyc >= 0) begin
      pv = exp_vld[rst_cyc];
      pd = exp_data[rst_cyc];
      for (int c = rst_cyc; c < MAXC; c++) exp_vld[c] = 1'b0;
    end
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      if (rst_cyc >= 0 && c == rst_cyc + 2) rst = 1'b1;
      bus.valid_in = in_vld[c];
      for (int k = 0; k < N; k++) bus.data_in[CW*k +: CW] = in_word[c][k];
      if (c == rst_cyc) begin
        #1;
        chk("pre_rst_valid", 64'(bus.valid_out), 64'(pv));
        if (pv) chk("pre_rst_data", 64'(bus.data_out), 64'(pd));
        rst = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.valid_out), 64'(0));
        chk("rst_data", 64'(bus.data_out), 64'(0));
        chk("rst_ovf", 64'(bus.overflow), 64'(0));
      end
      @(negedge clk);
      if (c < lim) begin
        chk($sformatf("valid_out@%0d", c), 64'(bus.valid_out), 64'(exp_vld[c]));
        if (exp_vld[c]) chk($sformatf("data_out@%0d", c), 64'(bus.data_out), 64'(exp_data[c]));
      end
      if (!stress) chk($sformatf("overflow@%0d", c), 64'(bus.overflow), 64'(0));
    end
    bus.valid_in = 1'b0;
  endtask

  initial begin
    logic [CW-1:0] w [N];
    int e;
    int t;

    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 64'(bus.valid_out), 64'(0));
    chk("reset_data", 64'(bus.data_out), 64'(0));
    chk("reset_ovf", 64'(bus.overflow), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    // Single wavefront 1..4
    clear_sched();
    for (int k = 0; k < N; k++) w[k] = CW'(k + 1);
    add_wave(0, w, e);
    run(12, -1, MAXC);

    // Interval 2, 8 wavefronts
    clear_sched();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < N; k++) w[k] = CW'($urandom);
      add_wave(2 * i, w, e);
    end
    run(30, -1, MAXC);

    // Interval 1, 10 wavefronts
    clear_sched();
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < N; k++) w[k] = CW'($urandom);
      add_wave(i, w, e);
    end
    run(35, -1, MAXC);

    // Random intervals 1..4, 20 wavefronts
    clear_sched();
    t = 0;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < N; k++) w[k] = CW'($urandom);
      add_wave(t, w, e);
      t += $urandom_range(1, 4);
    end
    run(last_e + S + 4, -1, MAXC);

    // Reset in cycle 3 of a wavefront
    clear_sched();
    for (int k = 0; k < N; k++) w[k] = CW'($urandom);
    add_wave(0, w, e);
    run(20, 3, MAXC);

    // Reset while the first beat is on the output
    clear_sched();
    for (int k = 0; k < N; k++) w[k] = CW'($urandom);
    add_wave(0, w, e);
    run(20, 5, MAXC);

    // Recovery after reset
    clear_sched();
    for (int k = 0; k < N; k++) w[k] = CW'($urandom);
    add_wave(0, w, e);
    run(12, -1, MAXC);

`ifdef DRAIN_OVERFLOW_CHK_EN
    begin
      int lim;
      lim = MAXC;
      clear_sched();
      stress = 1'b1;
      for (int i = 0; i < 140; i++) begin
        for (int k = 0; k < N; k++) w[k] = CW'($urandom);
        add_wave(i, w, e);
        if (i == QD - 1) lim = e + S;
      end
      run(160, -1, lim);
      chk("overflow_set", 64'(bus.overflow), 64'(1));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
